fp_cast_sched: RTL and testbench
================================

FP_CAST_SCHED -- requirements
Module: fp_cast_sched

Interface
REQ-001 Parameters SHALL be NUM_REQ (default 4, number of requesters, 2..8), TAG_WIDTH (default 4, requester tag width), CAST_LAT (default 1, cast unit pipe registers, 0..3), FP_WIDTH (default 32), RND_WIDTH (default 3), STAT_WIDTH (default 5).
REQ-002 Ports, listed as name, direction, width, meaning:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- Req_i  in  NUM_REQ  operation request, one bit per requester.
- OpA_i  in  NUM_REQ x FP_WIDTH  per-requester operand.
- F2I_i  in  NUM_REQ  per-requester direction select (1 = float to int).
- Rnd_i  in  NUM_REQ x RND_WIDTH  per-requester rounding mode.
- Tag_i  in  NUM_REQ x TAG_WIDTH  per-requester tag.
- Gnt_o  out  NUM_REQ  request accepted this cycle.
- RspReady_i  in  NUM_REQ  requester can take its result.
- RspValid_o  out  NUM_REQ  result held for the requester.
- Res_o  out  NUM_REQ x FP_WIDTH  result data.
- Status_o  out  NUM_REQ x STAT_WIDTH  result status.
- RspTag_o  out  NUM_REQ x TAG_WIDTH  returned tag.
- UnitEn_o  out  1  issue strobe to the cast unit.
- UnitF2I_o  out  1  direction to the cast unit.
- UnitOpA_o  out  FP_WIDTH  operand to the cast unit.
- UnitRnd_o  out  RND_WIDTH  rounding mode to the cast unit.
- UnitTag_o  out  IDW+TAG_WIDTH  tag to the cast unit; IDW = clog2(NUM_REQ); MSBs carry the requester id.
- UnitValid_i  in  1  result valid from the cast unit.
- UnitRes_i  in  FP_WIDTH  result from the cast unit.
- UnitStatus_i  in  STAT_WIDTH  status from the cast unit.
- UnitTag_i  in  IDW+TAG_WIDTH  returned tag from the cast unit.
- Err_o  out  1  one-cycle pulse on an orphan result.

Function
REQ-003 Each requester k SHALL have a 3-state FSM: IDLE, BUSY (op in flight), DONE (result buffered).
REQ-004 Requester k SHALL be eligible only when Req_i[k]=1 and its state is IDLE.
REQ-005 Gnt_o SHALL be combinational, one-hot or zero, and grant at most one eligible requester per cycle.
REQ-006 On a grant to k, the FSM SHALL go IDLE->BUSY, and the next cycle SHALL register UnitEn_o=1 with k's F2I, OpA, Rnd and {k,Tag}; with no grant, UnitEn_o=0 next cycle and the Unit* data outputs hold.
REQ-007 On UnitValid_i with id=UnitTag_i MSBs and requester id in BUSY, that requester SHALL register Res, Status and tag and go BUSY->DONE.
REQ-008 RspValid_o[k] SHALL be 1 exactly in DONE; the data SHALL stay stable while RspValid_o[k]=1.
REQ-009 RspValid_o[k]&RspReady_i[k] SHALL move DONE->IDLE; k is eligible again at the earliest in the following cycle.
REQ-010 End-to-end latency SHALL be grant cycle t -> UnitEn_o at t+1 -> UnitValid_i at t+1+CAST_LAT -> RspValid_o at t+2+CAST_LAT.
REQ-011 A UnitValid_i whose id is not BUSY, or is >= NUM_REQ, SHALL be dropped and SHALL pulse Err_o for one cycle; no state changes.
REQ-012 A grant and a unit result for different requesters in the same cycle SHALL both take effect.
REQ-013 Unit results SHALL never be back-pressured; at most one op per requester is in flight, so no buffer overflow is possible.

Reset
REQ-014 While rst_i=1, asynchronously:
- all FSMs SHALL be IDLE;
- Gnt_o, RspValid_o, UnitEn_o and Err_o SHALL be 0;
- all data outputs SHALL be 0;
- the arbitration pointer SHALL equal NUM_REQ-1.
REQ-015 Unit results arriving after reset mid-operation SHALL be treated as orphans (REQ-011).

Configuration
REQ-016 With FP_CAST_SCHED_RR_EN defined, arbitration SHALL be round-robin: search starts at pointer+1 modulo NUM_REQ, and the pointer updates to the granted index only on a grant.
REQ-017 Without FP_CAST_SCHED_RR_EN, arbitration SHALL be fixed priority with the lowest index winning; the pointer logic is absent.

Verification
REQ-018 Single op: Req_i=0001, OpA=0x40490FDB, F2I=1, Rnd=001, CAST_LAT=1 -> Gnt_o=0001 at t; UnitEn_o at t+1 with UnitTag={0,Tag}; RspValid_o[0] at t+3 with Res=0x00000003.
REQ-019 Round-robin: Req_i=1111 held, RspReady_i=1111, RR_EN defined -> grant order 0,1,2,3, then 0 after it returns to IDLE; with RR_EN undefined -> only eligible lowest index each cycle.
REQ-020 Back-pressure: RspReady_i[2]=0 for 10 cycles after DONE -> RspValid_o[2] and Res_o[2] stable; no grant to requester 2 until one cycle after the handshake.
REQ-021 Orphan: UnitValid_i=1 with UnitTag_i id=3 while requester 3 is IDLE -> Err_o=1 for one cycle; RspValid_o unchanged.
REQ-022 Reset mid-op: rst_i=1 for 2 cycles while requester 1 is BUSY -> all outputs 0; the late unit result produces Err_o and no RspValid_o.

Source files
------------

// File: rtl/fp_cast_sched.sv
// rtl/fp_cast_sched.sv - multi-requester scheduler in front of a shared FP cast unit
//
// Purpose:
//   Arbitrates NUM_REQ requesters onto one pipelined float<->int cast unit.
//   Each requester owns a three-state tracker (IDLE / BUSY / DONE), so it has
//   at most one operation in flight. A result is buffered per requester until
//   that requester takes it with a valid/ready handshake.
//
// Configuration macro:
//   FP_CAST_SCHED_RR_EN
//     defined   : round-robin arbitration with a pointer to the last grant
//     undefined : fixed priority, lowest index wins, no pointer register
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   Req_i              per-requester operation request
//   OpA_i, F2I_i,      per-requester operand, direction (1 = float to int),
//   Rnd_i, Tag_i       rounding mode and tag, packed requester 0 in the LSBs
//   Gnt_o              combinational one-hot grant (or zero)
//   RspReady_i         requester can take its buffered result
//   RspValid_o         result buffered for the requester (DONE state)
//   Res_o, Status_o,   buffered result, status and returned tag, packed
//   RspTag_o           requester 0 in the LSBs
//   UnitEn_o .. UnitTag_o    registered issue to the cast unit; the tag MSBs
//                            carry the requester id
//   UnitValid_i .. UnitTag_i result from the cast unit, never back-pressured
//   Err_o              one-cycle pulse when a unit result matches no BUSY requester

module fp_cast_sched #(
  parameter int NUM_REQ    = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int CAST_LAT   = 1,
  parameter int FP_WIDTH   = 32,
  parameter int RND_WIDTH  = 3,
  parameter int STAT_WIDTH = 5
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_REQ-1:0]                    Req_i,
  input  logic [NUM_REQ*FP_WIDTH-1:0]           OpA_i,
  input  logic [NUM_REQ-1:0]                    F2I_i,
  input  logic [NUM_REQ*RND_WIDTH-1:0]          Rnd_i,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]          Tag_i,
  output logic [NUM_REQ-1:0]                    Gnt_o,
  input  logic [NUM_REQ-1:0]                    RspReady_i,
  output logic [NUM_REQ-1:0]                    RspValid_o,
  output logic [NUM_REQ*FP_WIDTH-1:0]           Res_o,
  output logic [NUM_REQ*STAT_WIDTH-1:0]         Status_o,
  output logic [NUM_REQ*TAG_WIDTH-1:0]          RspTag_o,
  output logic                                  UnitEn_o,
  output logic                                  UnitF2I_o,
  output logic [FP_WIDTH-1:0]                   UnitOpA_o,
  output logic [RND_WIDTH-1:0]                  UnitRnd_o,
  output logic [$clog2(NUM_REQ)+TAG_WIDTH-1:0]  UnitTag_o,
  input  logic                                  UnitValid_i,
  input  logic [FP_WIDTH-1:0]                   UnitRes_i,
  input  logic [STAT_WIDTH-1:0]                 UnitStatus_i,
  input  logic [$clog2(NUM_REQ)+TAG_WIDTH-1:0]  UnitTag_i,
  output logic                                  Err_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int UTW = IDW + TAG_WIDTH;

  // The scheduler itself is latency agnostic: results are matched by the id
  // in the returned tag, so CAST_LAT only bounds the legal configuration.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ out of range 2..8");
  end
  if (CAST_LAT < 0 || CAST_LAT > 3) begin : g_bad_cast_lat
    $error("CAST_LAT out of range 0..3");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q [NUM_REQ];
  state_t               state_d [NUM_REQ];

  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_any;
  logic [IDW-1:0]       gnt_idx;
  logic [NUM_REQ-1:0]   res_hit;
  logic                 orphan;
  logic [IDW-1:0]       rsp_id;

  // Eligibility is forced low during reset so Gnt_o is zero while rst_i is high.
  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      elig[k] = Req_i[k] && (state_q[k] == ST_IDLE) && !rst_i;
    end
  end

`ifdef FP_CAST_SCHED_RR_EN
  logic [IDW-1:0] ptr_q;
  int             rr_idx;

  // Search starts one past the last granted index and wraps.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_idx  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_idx = (int'(ptr_q) + 1 + i) % NUM_REQ;
      if (!gnt_any && elig[rr_idx]) begin
        gnt[rr_idx] = 1'b1;
        gnt_any     = 1'b1;
        gnt_idx     = IDW'(rr_idx);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= IDW'(NUM_REQ - 1);
    end else if (gnt_any) begin
      ptr_q <= gnt_idx;
    end
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && elig[i]) begin
        gnt[i]  = 1'b1;
        gnt_any = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
  end
`endif

  assign Gnt_o = gnt;

  // A unit result is accepted only by the requester its id names, and only
  // while that requester is BUSY; ids >= NUM_REQ match nobody and fall out
  // as orphans.
  assign rsp_id = UnitTag_i[UTW-1 -: IDW];

  always_comb begin
    res_hit = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      res_hit[k] = UnitValid_i && (rsp_id == IDW'(k)) && (state_q[k] == ST_BUSY);
    end
    orphan = UnitValid_i && !(|res_hit);
  end

  // Per-requester trackers: state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        state_q[k] <= ST_IDLE;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        state_q[k] <= state_d[k];
      end
    end
  end

  // Per-requester trackers: next state and response valid.
  always_comb begin
    RspValid_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        ST_IDLE: if (gnt[k])        state_d[k] = ST_BUSY;
        ST_BUSY: if (res_hit[k])    state_d[k] = ST_DONE;
        ST_DONE: if (RspReady_i[k]) state_d[k] = ST_IDLE;
        default:                    state_d[k] = ST_IDLE;
      endcase
      RspValid_o[k] = (state_q[k] == ST_DONE);
    end
  end

  // Result buffers load only on a hit, which requires BUSY, so they stay
  // stable for the whole DONE period.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      Res_o    <= '0;
      Status_o <= '0;
      RspTag_o <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (res_hit[k]) begin
          Res_o[k*FP_WIDTH +: FP_WIDTH]       <= UnitRes_i;
          Status_o[k*STAT_WIDTH +: STAT_WIDTH] <= UnitStatus_i;
          RspTag_o[k*TAG_WIDTH +: TAG_WIDTH]  <= UnitTag_i[TAG_WIDTH-1:0];
        end
      end
    end
  end

  // Issue register toward the cast unit; data holds when nothing is granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      UnitEn_o  <= 1'b0;
      UnitF2I_o <= 1'b0;
      UnitOpA_o <= '0;
      UnitRnd_o <= '0;
      UnitTag_o <= '0;
      Err_o     <= 1'b0;
    end else begin
      UnitEn_o <= gnt_any;
      Err_o    <= orphan;
      if (gnt_any) begin
        UnitF2I_o <= F2I_i[gnt_idx];
        UnitOpA_o <= OpA_i[gnt_idx*FP_WIDTH +: FP_WIDTH];
        UnitRnd_o <= Rnd_i[gnt_idx*RND_WIDTH +: RND_WIDTH];
        UnitTag_o <= {gnt_idx, Tag_i[gnt_idx*TAG_WIDTH +: TAG_WIDTH]};
      end
    end
  end

endmodule

// File: tb/tb_fp_cast_sched.sv
// tb/tb_fp_cast_sched.sv - self-checking bench for fp_cast_sched with a behavioral cast unit

module tb_fp_cast_sched;

  localparam int NR  = 4;
  localparam int TW  = 4;
  localparam int LAT = 1;
  localparam int FW  = 32;
  localparam int RW  = 3;
  localparam int SW  = 5;
  localparam int IDW = 2;
  localparam int UTW = IDW + TW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR-1:0]    req, f2i, gnt, rsp_ready, rsp_valid;
  logic [NR*FW-1:0] opa, res;
  logic [NR*RW-1:0] rnd;
  logic [NR*TW-1:0] tag, rsp_tag;
  logic [NR*SW-1:0] status;
  logic             unit_en, unit_f2i;
  logic [FW-1:0]    unit_opa;
  logic [RW-1:0]    unit_rnd;
  logic [UTW-1:0]   unit_tag;
  logic             unit_valid;
  logic [FW-1:0]    unit_res;
  logic [SW-1:0]    unit_status;
  logic [UTW-1:0]   unit_tag_r;
  logic             err;

  int checks = 0;
  int errors = 0;

  fp_cast_sched #(
    .NUM_REQ(NR), .TAG_WIDTH(TW), .CAST_LAT(LAT),
    .FP_WIDTH(FW), .RND_WIDTH(RW), .STAT_WIDTH(SW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .Req_i(req), .OpA_i(opa), .F2I_i(f2i), .Rnd_i(rnd), .Tag_i(tag),
    .Gnt_o(gnt), .RspReady_i(rsp_ready), .RspValid_o(rsp_valid),
    .Res_o(res), .Status_o(status), .RspTag_o(rsp_tag),
    .UnitEn_o(unit_en), .UnitF2I_o(unit_f2i), .UnitOpA_o(unit_opa),
    .UnitRnd_o(unit_rnd), .UnitTag_o(unit_tag),
    .UnitValid_i(unit_valid), .UnitRes_i(unit_res),
    .UnitStatus_i(unit_status), .UnitTag_i(unit_tag_r),
    .Err_o(err)
  );

  // Behavioral cast unit: float->int truncates toward zero with saturation,
  // int->float is a simple bit transform that the scheduler passes through.
  function automatic logic [31:0] cast_res(input logic [31:0] op, input logic f);
    int sh;
    logic [31:0] m, v;
    if (!f) return {~op[31:16], op[15:0]};
    if (op[30:23] < 8'd127) return 32'h0;
    sh = int'(op[30:23]) - 127;
    if (sh > 30) return op[31] ? 32'h8000_0000 : 32'h7fff_ffff;
    m = {8'h00, 1'b1, op[22:0]};
    v = (sh >= 23) ? (m << (sh - 23)) : (m >> (23 - sh));
    return op[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [4:0] cast_status(input logic [31:0] op, input logic f,
                                             input logic [2:0] r);
    return {f & op[31], 1'b0, r};
  endfunction

  logic             mdl_valid = 1'b0;
  logic [FW-1:0]    mdl_res = '0;
  logic [SW-1:0]    mdl_status = '0;
  logic [UTW-1:0]   mdl_tag = '0;
  logic             inj_valid = 1'b0;
  logic [UTW-1:0]   inj_tag = '0;

  always @(posedge clk) begin
    mdl_valid  <= unit_en;
    mdl_res    <= cast_res(unit_opa, unit_f2i);
    mdl_status <= cast_status(unit_opa, unit_f2i, unit_rnd);
    mdl_tag    <= unit_tag;
  end

  assign unit_valid  = mdl_valid | inj_valid;
  assign unit_res    = inj_valid ? 32'hDEAD_BEEF : mdl_res;
  assign unit_status = inj_valid ? 5'h1F : mdl_status;
  assign unit_tag_r  = inj_valid ? inj_tag : mdl_tag;

  // Scoreboard: one entry per expected grant, checked when RspValid_o rises.
  typedef struct {
    int          id;
    logic [31:0] r;
    logic [4:0]  s;
    logic [3:0]  t;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [NR-1:0] prev_v = '0;

  task automatic push_exp(input int k);
    exp_t e;
    e.id = k;
    e.r  = cast_res(opa[k*FW +: FW], f2i[k]);
    e.s  = cast_status(opa[k*FW +: FW], f2i[k], rnd[k*RW +: RW]);
    e.t  = tag[k*TW +: TW];
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_v = '0;
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (rsp_valid[k] && !prev_v[k]) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected req=%0d res=%h (no result expected)", k, res[k*FW +: FW]);
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.id != k || res[k*FW +: FW] !== mon_e.r ||
                status[k*SW +: SW] !== mon_e.s || rsp_tag[k*TW +: TW] !== mon_e.t) begin
              errors++;
              $display("FAIL sb_result got req=%0d res=%h st=%h tag=%h exp req=%0d res=%h st=%h tag=%h",
                       k, res[k*FW +: FW], status[k*SW +: SW], rsp_tag[k*TW +: TW],
                       mon_e.id, mon_e.r, mon_e.s, mon_e.t);
            end
          end
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic [31:0] a, input logic f,
                        input logic [2:0] r, input logic [3:0] t);
    opa[k*FW +: FW] = a;
    f2i[k]          = f;
    rnd[k*RW +: RW] = r;
    tag[k*TW +: TW] = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0 || rsp_valid !== 4'b0 || unit_en !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl gnt=%b rv=%b en=%b err=%b exp all 0", gnt, rsp_valid, unit_en, err);
    end
    checks++;
    if (res !== '0 || status !== '0 || rsp_tag !== '0 || unit_opa !== '0 ||
        unit_tag !== '0 || unit_rnd !== '0 || unit_f2i !== 1'b0) begin
      errors++;
      $display("FAIL reset_data res=%h st=%h opa=%h utag=%h exp 0", res, status, unit_opa, unit_tag);
    end
    step();
    req = 4'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    set_op(0, 32'h40490FDB, 1'b1, 3'b001, 4'h5);
    rsp_ready = 4'b1111;
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL single_gnt got=%b exp=0001", gnt);
    end
    push_exp(0);
    step();
    req = 4'b0;
    @(negedge clk);
    checks++;
    if (unit_en !== 1'b1 || unit_tag !== {2'd0, 4'h5} || unit_opa !== 32'h40490FDB ||
        unit_f2i !== 1'b1 || unit_rnd !== 3'b001) begin
      errors++;
      $display("FAIL single_issue en=%b tag=%h opa=%h f2i=%b rnd=%b exp 1 05 40490fdb 1 001",
               unit_en, unit_tag, unit_opa, unit_f2i, unit_rnd);
    end
    step();
    @(negedge clk);
    checks++;
    if (unit_en !== 1'b0 || unit_opa !== 32'h40490FDB || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL single_hold en=%b opa=%h rv=%b exp 0 40490fdb 0000", unit_en, unit_opa, rsp_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0001 || res[31:0] !== 32'h0000_0003 || rsp_tag[3:0] !== 4'h5) begin
      errors++;
      $display("FAIL single_rsp rv=%b res=%h tag=%h exp 0001 00000003 5", rsp_valid, res[31:0], rsp_tag[3:0]);
    end
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL single_release rv=%b exp=0000", rsp_valid);
    end
  endtask

  task automatic test_arb_all();
    logic [NR-1:0] exp_g;
    rsp_ready = 4'b1111;
    step();
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      exp_g = 4'b0001 << (c % 4);
      @(negedge clk);
      checks++;
      if (gnt !== exp_g) begin
        errors++;
        $display("FAIL arb_all_c%0d got=%b exp=%b", c, gnt, exp_g);
      end
      push_exp(c % 4);
      step();
    end
    req = 4'b0;
    repeat (8) step();
  endtask

  task automatic test_arb_contention();
    int            exp_i [4];
    logic [NR-1:0] exp_g;
`ifdef FP_CAST_SCHED_RR_EN
    exp_i = '{2, 3, 0, 1};
`else
    exp_i = '{2, 0, 1, 3};
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int c = 0; c < 4; c++) begin
      req = (c == 0) ? 4'b0100 : 4'b1011;
      exp_g = 4'b0001 << exp_i[c];
      @(negedge clk);
      checks++;
      if (gnt !== exp_g) begin
        errors++;
        $display("FAIL arb_cont_c%0d got=%b exp=%b", c, gnt, exp_g);
      end
      push_exp(exp_i[c]);
      step();
    end
    req = 4'b0;
    repeat (8) step();
  endtask

  task automatic test_backpressure();
    logic [31:0] hold_r;
    bit          seen;
    hold_r = cast_res(opa[2*FW +: FW], f2i[2]);
    rsp_ready = 4'b1011;
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL bp_gnt got=%b exp=0100", gnt);
    end
    push_exp(2);
    step();
    req = 4'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid[2]) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_timeout rv=%b exp bit2 set within 10 cycles", rsp_valid);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      req = 4'b0100;
      @(negedge clk);
      checks++;
      if (rsp_valid[2] !== 1'b1 || res[2*FW +: FW] !== hold_r || gnt !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d rv2=%b res=%h gnt=%b exp 1 %h 0000",
                 i, rsp_valid[2], res[2*FW +: FW], gnt, hold_r);
      end
    end
    step();
    rsp_ready = 4'b1111;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0 || rsp_valid[2] !== 1'b1) begin
      errors++;
      $display("FAIL bp_handshake gnt=%b rv2=%b exp 0000 1", gnt, rsp_valid[2]);
    end
    step();
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || rsp_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL bp_regrant gnt=%b rv2=%b exp 0100 0", gnt, rsp_valid[2]);
    end
    push_exp(2);
    step();
    req = 4'b0;
    repeat (6) step();
  endtask

  task automatic test_orphan();
    logic [31:0] hold_r;
    bit          seen;
    inj_valid = 1'b1;
    inj_tag   = {2'd3, 4'hA};
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL orphan_pre err=%b exp=0", err);
    end
    step();
    inj_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL orphan_idle err=%b rv=%b exp 1 0000", err, rsp_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL orphan_pulse err=%b exp=0", err);
    end
    hold_r = cast_res(opa[0 +: FW], f2i[0]);
    rsp_ready = 4'b1110;
    req = 4'b0001;
    @(negedge clk);
    push_exp(0);
    step();
    req = 4'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid[0]) seen = 1'b1;
      else step();
    end
    step();
    inj_valid = 1'b1;
    inj_tag   = {2'd0, 4'h7};
    step();
    inj_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (!seen || err !== 1'b1 || rsp_valid[0] !== 1'b1 || res[0 +: FW] !== hold_r) begin
      errors++;
      $display("FAIL orphan_done seen=%b err=%b rv0=%b res=%h exp 1 1 1 %h",
               seen, err, rsp_valid[0], res[0 +: FW], hold_r);
    end
    step();
    rsp_ready = 4'b1111;
    repeat (3) step();
  endtask

  task automatic test_reset_midop();
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL rmid_gnt got=%b exp=0010", gnt);
    end
    step();
    req = 4'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (unit_en !== 1'b0 || rsp_valid !== 4'b0 || gnt !== 4'b0 || err !== 1'b0 ||
        unit_opa !== '0 || unit_tag !== '0 || res !== '0) begin
      errors++;
      $display("FAIL rmid_clear en=%b rv=%b gnt=%b err=%b opa=%h utag=%h exp all 0",
               unit_en, rsp_valid, gnt, err, unit_opa, unit_tag);
    end
    step();
    step();
    rst = 1'b0;
    inj_valid = 1'b1;
    inj_tag   = {2'd1, tag[1*TW +: TW]};
    step();
    inj_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL rmid_late err=%b rv=%b exp 1 0000", err, rsp_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL rmid_after err=%b rv=%b exp 0 0000", err, rsp_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    rsp_ready = 4'b1111;
    opa = '0;
    f2i = '0;
    rnd = '0;
    tag = '0;
    test_reset();
    test_single();
    set_op(0, 32'h40000000, 1'b1, 3'b001, 4'h1);
    set_op(1, 32'h40A00000, 1'b1, 3'b000, 4'h2);
    set_op(2, 32'h12345678, 1'b0, 3'b010, 4'h3);
    set_op(3, 32'hC2F60000, 1'b1, 3'b011, 4'h4);
    test_arb_all();
    test_arb_contention();
    test_backpressure();
    test_orphan();
    test_reset_midop();
    repeat (4) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
